// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared glyph table and state enum for seven-segment capture
package seven_segment_pkg;

   typedef enum logic {st_collect, st_publish} state_t;

   // a..g patterns, index = hex value; bit6 = a, bit0 = g
   localparam logic [6:0] glyph [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

endpackage

// File: rtl/seven_segment_decoder.sv
// rtl/seven_segment_decoder.sv - combinational a..g pattern to hex nibble decoder
import seven_segment_pkg::*;

module seven_segment_decoder (
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       err
);

   // unknown patterns, including blank, decode to 0 flagged as error
   always_comb begin
      nibble = '0;
      err    = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (seg == glyph[i]) begin
            nibble = 4'(i);
            err    = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seven_segment_capture.sv
// rtl/seven_segment_capture.sv - captures a multiplexed seven-segment display into hex frames
import seven_segment_pkg::*;

module seven_segment_capture #(
   parameter int w_digit       = 8,
   parameter int stable_cycles = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             abcdefgh,
   input  logic [w_digit-1:0]     digit,
   output logic [4*w_digit-1:0]   frame,
   output logic [w_digit-1:0]     frame_dp,
   output logic [w_digit-1:0]     frame_err,
   output logic                   frame_valid,
   output logic                   multi_hot_err
);

   logic [w_digit-1:0]   dig_q, dig_p;
   logic [7:0]           seg_q, seg_p;
   logic [7:0]           cnt;
   logic [4*w_digit-1:0] shadow_nib;
   logic [w_digit-1:0]   shadow_dp, shadow_err, seen, seen_n;
   state_t               state, state_n;

   logic       same, at_point, one_hot, any_hot, capture;
   logic [3:0] dec_nib;
   logic       dec_err;

   seven_segment_decoder u_decoder (
      .seg    (seg_q[7:1]),
      .nibble (dec_nib),
      .err    (dec_err)
   );

   assign same     = (dig_q == dig_p) && (seg_q == seg_p);
   // capture fires on the edge where the counter reaches stable_cycles-1
   assign at_point = same && (cnt == 8'(stable_cycles - 2));
   assign any_hot  = (dig_q != '0);
   assign one_hot  = any_hot && ((dig_q & (dig_q - w_digit'(1))) == '0);
   assign capture  = at_point && one_hot;

   always_comb begin
      state_n = state;
      case (state)
         st_collect: if (&seen) state_n = st_publish;
         st_publish: state_n = st_collect;
         default:    state_n = st_collect;
      endcase
   end

   // a capture landing in PUBLISH starts the next frame's mask
   always_comb begin
      seen_n = (state == st_publish) ? '0 : seen;
      if (capture) seen_n = seen_n | dig_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dig_q <= '0;
         dig_p <= '0;
         seg_q <= '0;
         seg_p <= '0;
         cnt   <= '0;
      end else begin
         dig_q <= digit;
         seg_q <= abcdefgh;
         dig_p <= dig_q;
         seg_p <= seg_q;
         if (!same)
            cnt <= '0;
         else if (cnt < 8'(stable_cycles))
            cnt <= cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= st_collect;
         seen          <= '0;
         shadow_nib    <= '0;
         shadow_dp     <= '0;
         shadow_err    <= '0;
         multi_hot_err <= 1'b0;
      end else begin
         state <= state_n;
         seen  <= seen_n;
         if (at_point && any_hot && !one_hot)
            multi_hot_err <= 1'b1;
         for (int i = 0; i < w_digit; i++) begin
            if (capture && dig_q[i]) begin
               shadow_nib[4*i +: 4] <= dec_nib;
               shadow_dp[i]         <= seg_q[0];
               shadow_err[i]        <= dec_err;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame       <= '0;
         frame_dp    <= '0;
         frame_err   <= '0;
         frame_valid <= 1'b0;
      end else begin
         frame_valid <= (state == st_publish);
         if (state == st_publish) begin
            frame     <= shadow_nib;
            frame_dp  <= shadow_dp;
            frame_err <= shadow_err;
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_capture.sv
// tb/tb_seven_segment_capture.sv - directed self-checking bench for seven_segment_capture
module tb_seven_segment_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  abcdefgh;
   logic [7:0]  digit;
   logic [31:0] frame;
   logic [7:0]  frame_dp;
   logic [7:0]  frame_err;
   logic        frame_valid;
   logic        multi_hot_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int fv_count = 0;
   int fv_q[$];

   seven_segment_capture #(.w_digit(8), .stable_cycles(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .abcdefgh      (abcdefgh),
      .digit         (digit),
      .frame         (frame),
      .frame_dp      (frame_dp),
      .frame_err     (frame_err),
      .frame_valid   (frame_valid),
      .multi_hot_err (multi_hot_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst && frame_valid) begin
         fv_count++;
         fv_q.push_back(cyc);
      end
   end

   function automatic logic [7:0] seg_of(input int v, input logic dp);
      logic [6:0] g;
      case (v)
         0:  g = 7'b1111110;  1:  g = 7'b0110000;  2:  g = 7'b1101101;  3:  g = 7'b1111001;
         4:  g = 7'b0110011;  5:  g = 7'b1011011;  6:  g = 7'b1011111;  7:  g = 7'b1110000;
         8:  g = 7'b1111111;  9:  g = 7'b1111011;  10: g = 7'b1110111;  11: g = 7'b0011111;
         12: g = 7'b1001110;  13: g = 7'b0111101;  14: g = 7'b1001111;  15: g = 7'b1000111;
         default: g = 7'b0000000;
      endcase
      return {g, dp};
   endfunction

   function automatic logic [7:0] slot(input int i);
      logic [7:0] one;
      one = 8'd1;
      return one << i;
   endfunction

   task automatic show(input logic [7:0] d, input logic [7:0] s, input int n);
      digit    = d;
      abcdefgh = s;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      digit = '0;
      abcdefgh = '0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (frame !== 32'h0)       begin bad++; $display("FAIL reset_frame got=%h exp=%h", frame, 32'h0); end
      total++; if (frame_dp !== 8'h0)     begin bad++; $display("FAIL reset_dp got=%h exp=%h", frame_dp, 8'h0); end
      total++; if (frame_err !== 8'h0)    begin bad++; $display("FAIL reset_err got=%h exp=%h", frame_err, 8'h0); end
      total++; if (frame_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b exp=0", frame_valid); end
      total++; if (multi_hot_err !== 1'b0) begin bad++; $display("FAIL reset_multi got=%b exp=0", multi_hot_err); end
      rst = 1'b1;
      show(8'h00, 8'h00, 3);
   endtask

   task automatic test_scan;
      int base, lat;
      base = fv_count;
      lat  = -1;
      for (int i = 0; i < 7; i++) show(slot(i), seg_of(i, 1'b0), 6);
      digit    = slot(7);
      abcdefgh = seg_of(7, 1'b0);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (frame_valid && lat < 0) lat = k;
      end
      @(posedge clk); #1;
      show(8'h00, 8'h00, 4);
      total++; if (fv_count - base !== 1) begin bad++; $display("FAIL scan_count got=%0d exp=1", fv_count - base); end
      total++; if (lat !== 7)             begin bad++; $display("FAIL scan_latency got=%0d exp=7", lat); end
      total++; if (frame !== 32'h76543210) begin bad++; $display("FAIL scan_frame got=%h exp=%h", frame, 32'h76543210); end
      total++; if (frame_err !== 8'h00)   begin bad++; $display("FAIL scan_err got=%h exp=00", frame_err); end
      total++; if (frame_dp !== 8'h00)    begin bad++; $display("FAIL scan_dp got=%h exp=00", frame_dp); end
   endtask

   task automatic test_short_strobe;
      int base;
      base = fv_count;
      for (int i = 0; i < 7; i++) show(slot(i), seg_of(15 - i, i == 3), 6);
      show(slot(7), seg_of(8, 1'b0), 3);
      show(8'h00, 8'h00, 10);
      total++; if (fv_count - base !== 0) begin bad++; $display("FAIL short_no_capture got=%0d exp=0", fv_count - base); end
      show(slot(7), seg_of(8, 1'b0), 6);
      show(8'h00, 8'h00, 6);
      total++; if (fv_count - base !== 1) begin bad++; $display("FAIL short_then_full got=%0d exp=1", fv_count - base); end
      total++; if (frame !== 32'h89ABCDEF) begin bad++; $display("FAIL short_frame got=%h exp=%h", frame, 32'h89ABCDEF); end
      total++; if (frame_dp !== 8'h08)    begin bad++; $display("FAIL short_dp got=%h exp=08", frame_dp); end
   endtask

   task automatic test_multi_and_bad_glyph;
      int base;
      base = fv_count;
      show(8'b0000_0011, seg_of(1, 1'b0), 10);
      show(8'h00, 8'h00, 2);
      total++; if (multi_hot_err !== 1'b1) begin bad++; $display("FAIL multi_set got=%b exp=1", multi_hot_err); end
      for (int i = 2; i < 8; i++) show(slot(i), (i == 2) ? 8'b1010_1010 : seg_of(i, 1'b0), 6);
      show(8'h00, 8'h00, 6);
      total++; if (fv_count - base !== 0) begin bad++; $display("FAIL multi_seen_untouched got=%0d exp=0", fv_count - base); end
      for (int i = 0; i < 2; i++) show(slot(i), seg_of(i, 1'b0), 6);
      show(8'h00, 8'h00, 6);
      total++; if (fv_count - base !== 1)  begin bad++; $display("FAIL badglyph_count got=%0d exp=1", fv_count - base); end
      total++; if (frame !== 32'h76543010) begin bad++; $display("FAIL badglyph_frame got=%h exp=%h", frame, 32'h76543010); end
      total++; if (frame_err !== 8'h04)    begin bad++; $display("FAIL badglyph_err got=%h exp=04", frame_err); end
      total++; if (multi_hot_err !== 1'b1) begin bad++; $display("FAIL multi_sticky got=%b exp=1", multi_hot_err); end
   endtask

   task automatic test_reset_mid_frame;
      int base;
      for (int i = 0; i < 5; i++) show(slot(i), seg_of(i, 1'b1), 6);
      rst = 1'b0;
      digit = '0;
      abcdefgh = '0;
      #1;
      total++; if (frame !== 32'h0)        begin bad++; $display("FAIL midrst_frame got=%h exp=0", frame); end
      total++; if (multi_hot_err !== 1'b0) begin bad++; $display("FAIL midrst_multi got=%b exp=0", multi_hot_err); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      base = fv_count;
      for (int i = 5; i < 8; i++) show(slot(i), seg_of(15 - i, 1'b0), 6);
      show(8'h00, 8'h00, 6);
      total++; if (fv_count - base !== 0) begin bad++; $display("FAIL midrst_partial got=%0d exp=0", fv_count - base); end
      for (int i = 0; i < 5; i++) show(slot(i), seg_of(15 - i, 1'b0), 6);
      show(8'h00, 8'h00, 6);
      total++; if (fv_count - base !== 1)  begin bad++; $display("FAIL midrst_count got=%0d exp=1", fv_count - base); end
      total++; if (frame !== 32'h89ABCDEF) begin bad++; $display("FAIL midrst_frame_new got=%h exp=%h", frame, 32'h89ABCDEF); end
   endtask

   task automatic test_back_to_back;
      fv_q.delete();
      for (int p = 0; p < 4; p++)
         for (int i = 0; i < 8; i++) show(slot(i), seg_of(i, 1'b0), 5);
      show(8'h00, 8'h00, 8);
      total++; if (fv_q.size() !== 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", fv_q.size()); end
      for (int i = 1; i < fv_q.size(); i++) begin
         total++;
         if (fv_q[i] - fv_q[i-1] !== 40) begin
            bad++; $display("FAIL b2b_interval idx=%0d got=%0d exp=40", i, fv_q[i] - fv_q[i-1]);
         end
      end
      total++; if (frame !== 32'h76543210) begin bad++; $display("FAIL b2b_frame got=%h exp=%h", frame, 32'h76543210); end
   endtask

   initial begin
      test_reset;
      test_scan;
      test_short_strobe;
      test_multi_and_bad_glyph;
      test_reset_mid_frame;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
